// File: rtl/serial_audio_encoder.sv
// Parallel-to-serial audio transmitter: 24-bit PCM in over valid/ready, sclk/lrclk/sdout out
// in Left Justified or I2S framing, all derived from a single x128 fs master clock.
module serial_audio_encoder #(
  parameter int unsigned width = 24
) (
  input  logic             clk128,
  input  logic             reset,
  input  logic             is_i2s,
  input  logic             lrclk_polarity,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic             i_is_left,
  input  logic [width-1:0] i_audio,
  output logic             sclk,
  output logic             lrclk,
  output logic             sdout,
  output logic             underrun
);

  localparam int unsigned CntW = 7;
  localparam int unsigned BitW = 5;
  localparam logic [CntW-1:0] LoadL = CntW'(127);
  localparam logic [CntW-1:0] LoadR = CntW'(63);

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             fmt_q, fmt_d;
  logic             pol_q, pol_d;
  logic             primed_q, primed_d;
  logic [width-1:0] hold_l_q, hold_l_d;
  logic [width-1:0] hold_r_q, hold_r_d;
  logic [width-1:0] shift_l_q, shift_l_d;
  logic [width-1:0] shift_r_q, shift_r_d;
  logic             full_l_q, full_l_d;
  logic             full_r_q, full_r_d;
  logic             sclk_q, sclk_d;
  logic             lrclk_q, lrclk_d;
  logic             sdout_q, sdout_d;
  logic             underrun_q, underrun_d;

  logic             load_l, load_r;
  logic             acc_l, acc_r;
  logic [BitW-1:0]  bit_d;
  logic [width-1:0] active_d;
  logic [width-1:0] shifted_d;

  // Readiness depends only on the selected channel's holding flag, never on i_valid
  assign i_ready = ~reset & ~(i_is_left ? full_l_q : full_r_q);
  assign acc_l   = i_valid & i_ready & i_is_left;
  assign acc_r   = i_valid & i_ready & ~i_is_left;
  assign load_l  = (cnt_q == LoadL);
  assign load_r  = (cnt_q == LoadR);

  // Counter, mode capture, holding and slot registers
  always_comb begin : next_state
    cnt_d     = cnt_q + CntW'(1);
    fmt_d     = fmt_q;
    pol_d     = pol_q;
    primed_d  = primed_q | load_l;
    hold_l_d  = hold_l_q;
    hold_r_d  = hold_r_q;
    shift_l_d = shift_l_q;
    shift_r_d = shift_r_q;
    full_l_d  = full_l_q;
    full_r_d  = full_r_q;

    if (load_l) begin
      fmt_d     = is_i2s;
      pol_d     = lrclk_polarity;
      shift_l_d = full_l_q ? hold_l_q : '0;
      full_l_d  = 1'b0;
    end
    if (load_r) begin
      shift_r_d = full_r_q ? hold_r_q : '0;
      full_r_d  = 1'b0;
    end
    // A same-cycle accept lands after the load, so the new sample waits for the next frame
    if (acc_l) begin
      hold_l_d = i_audio;
      full_l_d = 1'b1;
    end
    if (acc_r) begin
      hold_r_d = i_audio;
      full_r_d = 1'b1;
    end
  end

  // Serial outputs are computed from next-cycle state so the registers line up with cnt
  always_comb begin : next_outputs
    bit_d      = cnt_d[5:1];
    active_d   = cnt_d[6] ? shift_r_d : shift_l_d;
    shifted_d  = active_d << (fmt_d ? (bit_d - BitW'(1)) : bit_d);
    sclk_d     = cnt_d[0];
    lrclk_d    = cnt_d[6] ^ pol_d;
    sdout_d    = (fmt_d && (bit_d == '0)) ? 1'b0 : shifted_d[width-1];
    underrun_d = primed_d & (((cnt_d == LoadR) & ~full_r_d) |
                             ((cnt_d == LoadL) & ~full_l_d));
  end

  always_ff @(posedge clk128) begin
    if (reset) begin
      cnt_q      <= '0;
      fmt_q      <= 1'b0;
      pol_q      <= 1'b0;
      primed_q   <= 1'b0;
      hold_l_q   <= '0;
      hold_r_q   <= '0;
      shift_l_q  <= '0;
      shift_r_q  <= '0;
      full_l_q   <= 1'b0;
      full_r_q   <= 1'b0;
      sclk_q     <= 1'b0;
      lrclk_q    <= 1'b0;
      sdout_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      fmt_q      <= fmt_d;
      pol_q      <= pol_d;
      primed_q   <= primed_d;
      hold_l_q   <= hold_l_d;
      hold_r_q   <= hold_r_d;
      shift_l_q  <= shift_l_d;
      shift_r_q  <= shift_r_d;
      full_l_q   <= full_l_d;
      full_r_q   <= full_r_d;
      sclk_q     <= sclk_d;
      lrclk_q    <= lrclk_d;
      sdout_q    <= sdout_d;
      underrun_q <= underrun_d;
    end
  end

  assign sclk     = sclk_q;
  assign lrclk    = lrclk_q;
  assign sdout    = sdout_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_serial_audio_encoder.sv
// Bench for serial_audio_encoder: frame-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_serial_audio_encoder;

  localparam int unsigned W  = 24;
  localparam int          WI = 24;

  logic         clk128 = 1'b0;
  logic         reset = 1'b1;
  logic         is_i2s = 1'b0;
  logic         lrclk_polarity = 1'b0;
  logic         i_valid = 1'b0;
  logic         i_is_left = 1'b0;
  logic [W-1:0] i_audio = '0;
  logic         i_ready, sclk, lrclk, sdout, underrun;

  int ncmp = 0;
  int nfail = 0;

  serial_audio_encoder #(.width(W)) dut (
    .clk128(clk128), .reset(reset), .is_i2s(is_i2s), .lrclk_polarity(lrclk_polarity),
    .i_valid(i_valid), .i_ready(i_ready), .i_is_left(i_is_left), .i_audio(i_audio),
    .sclk(sclk), .lrclk(lrclk), .sdout(sdout), .underrun(underrun)
  );

  always #5 clk128 = ~clk128;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: state as it stands during the current clk128 cycle
  int           mcnt = 0;
  bit           started = 0;
  bit           mfmt = 0, mpol = 0, mprimed = 0, mfull_l = 0, mfull_r = 0;
  logic [W-1:0] mhold_l = '0, mhold_r = '0, mplay_l = '0, mplay_r = '0;
  bit           macc_l, macc_r;

  always @(posedge clk128) begin
    if (reset) begin
      started = 1; mcnt = 0; mfmt = 0; mpol = 0; mprimed = 0;
      mfull_l = 0; mfull_r = 0; mhold_l = '0; mhold_r = '0; mplay_l = '0; mplay_r = '0;
    end else begin
      macc_l = i_valid && i_is_left && !mfull_l;
      macc_r = i_valid && !i_is_left && !mfull_r;
      if (mcnt == 127) begin
        mplay_l = mfull_l ? mhold_l : '0; mfull_l = 0;
        mfmt = is_i2s; mpol = lrclk_polarity; mprimed = 1;
      end
      if (mcnt == 63) begin
        mplay_r = mfull_r ? mhold_r : '0; mfull_r = 0;
      end
      if (macc_l) begin mhold_l = i_audio; mfull_l = 1; end
      if (macc_r) begin mhold_r = i_audio; mfull_r = 1; end
      mcnt = (mcnt + 1) % 128;
    end
  end

  function automatic logic exp_sd(input int k, input bit fmt, input logic [W-1:0] s);
    int b;
    logic [31:0] t;
    b = (k / 2) % 32;
    t = 32'(s);
    if (!fmt && b < WI) begin t = t >> (WI - 1 - b); return t[0]; end
    if (fmt && b >= 1 && b <= WI) begin t = t >> (WI - b); return t[0]; end
    return 1'b0;
  endfunction

  // Per-cycle compare plus a deserializer that rebuilds each slot word from sdout
  logic [W-1:0] rx = '0, rx_l = '0, rx_r = '0;
  int           ur_seen = 0, sd_ones = 0;
  int           cb;
  logic         e_ur;

  always @(negedge clk128) begin
    if (started) begin
      e_ur = mprimed && ((mcnt == 63 && !mfull_r) || (mcnt == 127 && !mfull_l));
      chk("sclk", 32'(sclk), 32'(mcnt % 2));
      chk("lrclk", 32'(lrclk), 32'((mcnt / 64) ^ int'(mpol)));
      chk("sdout", 32'(sdout), 32'(exp_sd(mcnt, mfmt, (mcnt >= 64) ? mplay_r : mplay_l)));
      chk("underrun", 32'(underrun), 32'(e_ur));
      chk("i_ready", 32'(i_ready),
          32'(!reset && !(i_is_left ? mfull_l : mfull_r)));
      if (underrun === 1'b1) ur_seen++;
      if (sdout === 1'b1) sd_ones++;
      if (reset) begin
        rx = '0; rx_l = '0; rx_r = '0;
      end else if (mcnt % 2 == 1) begin
        cb = (mcnt / 2) % 32;
        if ((!mfmt && cb < WI) || (mfmt && cb >= 1 && cb <= WI)) rx = {rx[W-2:0], sdout};
        if (mcnt == 63) begin rx_l = rx; rx = '0; end
        if (mcnt == 127) begin rx_r = rx; rx = '0; end
      end
    end
  end

  task automatic wait_cnt(input int k);
    int g;
    g = 0;
    @(posedge clk128); #1;
    while (mcnt != k && g < 300) begin @(posedge clk128); #1; g++; end
    chk("wait_cnt", 32'(mcnt), 32'(k));
  endtask

  task automatic send(input bit left, input logic [W-1:0] d);
    logic rdy;
    int   g;
    g = 0;
    i_valid = 1'b1; i_is_left = left; i_audio = d;
    do begin
      @(negedge clk128); rdy = i_ready;
      @(posedge clk128); #1; g++;
    end while (!rdy && g < 300);
    i_valid = 1'b0;
    chk("send_accept", 32'(rdy), 32'd1);
  endtask

  int   ur0, sd0, rcnt, g;
  logic rdy;

  initial begin
    // Reset values
    repeat (3) @(posedge clk128);
    #1;
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_lrclk", 32'(lrclk), 32'd0);
    chk("rst_sdout", 32'(sdout), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_ready", 32'(i_ready), 32'd0);
    reset = 1'b0;

    // Idle after reset: silence, underrun only from the second frame on
    ur0 = ur_seen; sd0 = sd_ones;
    wait_cnt(0);
    chk("ur_first_frame", 32'(ur_seen - ur0), 32'd0);
    ur0 = ur_seen;
    repeat (256) @(posedge clk128);
    #1;
    chk("ur_two_frames", 32'(ur_seen - ur0), 32'd4);
    chk("idle_silent", 32'(sd_ones - sd0), 32'd0);

    // LJ, polarity 0
    wait_cnt(2);  send(1'b1, 24'hA5A5A5);
    wait_cnt(70); send(1'b0, 24'h123456);
    wait_cnt(0);
    chk("lj_msb", 32'(sdout), 32'd1);
    chk("lj_lrclk_left", 32'(lrclk), 32'd0);
    chk("lj_sclk_even", 32'(sclk), 32'd0);
    @(posedge clk128); #1;
    chk("lj_sclk_odd", 32'(sclk), 32'd1);
    wait_cnt(20); send(1'b1, 24'h800001);
    is_i2s = 1'b1; lrclk_polarity = 1'b1;
    wait_cnt(70);
    chk("lj_lrclk_right", 32'(lrclk), 32'd1);
    wait_cnt(0);
    chk("lj_word_l", 32'(rx_l), 32'h00A5A5A5);
    chk("lj_word_r", 32'(rx_r), 32'h00123456);

    // I2S, polarity 1
    chk("i2s_lrclk_left", 32'(lrclk), 32'd1);
    chk("i2s_b0", 32'(sdout), 32'd0);
    wait_cnt(2);  chk("i2s_msb", 32'(sdout), 32'd1);
    wait_cnt(48); chk("i2s_lsb", 32'(sdout), 32'd1);
    wait_cnt(50); chk("i2s_pad", 32'(sdout), 32'd0);
    wait_cnt(0);
    chk("i2s_word_l", 32'(rx_l), 32'h00800001);

    // Backpressure on two back-to-back left samples
    wait_cnt(5); send(1'b1, 24'd1);
    i_valid = 1'b1; i_is_left = 1'b1; i_audio = 24'd2;
    g = 0; rcnt = -1;
    do begin
      @(negedge clk128); rdy = i_ready; rcnt = mcnt;
      @(posedge clk128); #1; g++;
    end while (!rdy && g < 300);
    i_valid = 1'b0;
    chk("bp_ready", 32'(rdy), 32'd1);
    chk("bp_ready_cnt", 32'(rcnt), 32'd0);
    wait_cnt(64); chk("bp_first", 32'(rx_l), 32'd1);
    wait_cnt(64); chk("bp_second", 32'(rx_l), 32'd2);

    // Right-channel accept colliding with its load
    wait_cnt(63);
    i_valid = 1'b1; i_is_left = 1'b0; i_audio = 24'h0F0F0F;
    @(negedge clk128);
    chk("col_underrun", 32'(underrun), 32'd1);
    chk("col_ready", 32'(i_ready), 32'd1);
    @(posedge clk128); #1;
    i_valid = 1'b0;
    chk("col_full_after", 32'(i_ready), 32'd0);
    wait_cnt(0);  chk("col_silent", 32'(rx_r), 32'd0);
    wait_cnt(10); send(1'b1, 24'hC00000);
    wait_cnt(0);  chk("col_next_frame", 32'(rx_r), 32'h000F0F0F);

    // Format change mid-frame only takes effect at the frame boundary
    chk("mode_b0_i2s", 32'(sdout), 32'd0);
    wait_cnt(2);  chk("mode_msb_i2s", 32'(sdout), 32'd1);
    wait_cnt(30); is_i2s = 1'b0;
    wait_cnt(40); send(1'b1, 24'hC00000);
    wait_cnt(0);  chk("mode_msb_lj", 32'(sdout), 32'd1);
    wait_cnt(4);  chk("mode_bit21_lj", 32'(sdout), 32'd0);

    // Mid-frame reset
    wait_cnt(90);
    i_is_left = 1'b1;
    reset = 1'b1;
    @(posedge clk128); #1;
    chk("mrst_sclk", 32'(sclk), 32'd0);
    chk("mrst_lrclk", 32'(lrclk), 32'd0);
    chk("mrst_sdout", 32'(sdout), 32'd0);
    chk("mrst_underrun", 32'(underrun), 32'd0);
    chk("mrst_ready", 32'(i_ready), 32'd0);
    @(posedge clk128); #1;
    reset = 1'b0;
    wait_cnt(30); send(1'b1, 24'h3C3C3C);
    repeat (300) @(posedge clk128);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    nfail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $fatal(1, "watchdog expired");
  end

endmodule
